network_controller: RTL and testbench



---
 rtl/network_controller.sv | 82 ++++++++
 tb/tb_network_controller.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/network_controller.sv
// rtl/network_controller.sv - layer sequencer for the neural-network datapath
//
// Steps the network through layers 0..LAST_LAYER. Each layer starts the RAM
// controller (LOAD), then the multi-sum stage (SUM). Each step waits for the
// shared done handshake. The layer index then advances (ADVANCE) and the
// sequencer returns to IDLE.
//
// Ports:
//   clk                 system clock, rising edge
//   reset               synchronous, active-high
//   start               run the layer at index `layer` (sampled in IDLE only)
//   done                completion from the active sub-block (LOAD/SUM only)
//   layer_sel           0 = external network input, 1 = previous layer output
//   layer               current / next layer index
//   sum_trigger         multi-sum stage run command
//   RAM_Controll_Start  RAM controller run command

module network_controller #(
    parameter int unsigned LAST_LAYER = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       done,
    output logic       layer_sel,
    output logic [1:0] layer,
    output logic       sum_trigger,
    output logic       RAM_Controll_Start
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        SUM     = 2'd2,
        ADVANCE = 2'd3
    } state_t;

    localparam logic [1:0] LAST = LAST_LAYER[1:0];

    state_t     state;
    state_t     state_next;
    logic [1:0] layer_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            layer <= 2'd0;
        end else begin
            state <= state_next;
            layer <= layer_next;
        end
    end

    always_comb begin
        state_next         = state;
        layer_next         = layer;
        sum_trigger        = 1'b0;
        RAM_Controll_Start = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = LOAD;
            end
            LOAD: begin
                RAM_Controll_Start = 1'b1;
                if (done) state_next = SUM;
            end
            SUM: begin
                sum_trigger = 1'b1;
                if (done) state_next = ADVANCE;
            end
            ADVANCE: begin
                // Wrapping to 0 after the final layer marks the pass complete.
                layer_next = (layer == LAST) ? 2'd0 : layer + 2'd1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign layer_sel = (layer != 2'd0);

endmodule

// File: tb/tb_network_controller.sv
// tb/tb_network_controller.sv - self-checking bench for network_controller

module tb_network_controller;

    localparam int LAST = 2;

    localparam int PH_IDLE  = 0;
    localparam int PH_FETCH = 1;
    localparam int PH_ADD   = 2;
    localparam int PH_NEXT  = 3;

    logic       clk;
    logic       reset;
    logic       start;
    logic       done;
    logic       layer_sel;
    logic [1:0] layer;
    logic       sum_trigger;
    logic       RAM_Controll_Start;

    int checks;
    int failures;

    int m_phase;
    int m_layer;
    bit m_valid;

    network_controller #(.LAST_LAYER(LAST)) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .done               (done),
        .layer_sel          (layer_sel),
        .layer              (layer),
        .sum_trigger        (sum_trigger),
        .RAM_Controll_Start (RAM_Controll_Start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference behaviour: which phase of the layer the controller is in and
    // which layer it is on, advanced by the handshake rules.
    always @(posedge clk) begin
        if (reset) begin
            m_phase = PH_IDLE;
            m_layer = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_phase == PH_IDLE) begin
                if (start) m_phase = PH_FETCH;
            end else if (m_phase == PH_FETCH) begin
                if (done) m_phase = PH_ADD;
            end else if (m_phase == PH_ADD) begin
                if (done) m_phase = PH_NEXT;
            end else begin
                m_layer = (m_layer + 1) % (LAST + 1);
                m_phase = PH_IDLE;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_ram_start", int'(RAM_Controll_Start), int'(m_phase == PH_FETCH));
            chk("model_sum_trigger", int'(sum_trigger), int'(m_phase == PH_ADD));
            chk("model_layer", int'(layer), m_layer);
            chk("model_layer_sel", int'(layer_sel), int'(m_layer != 0));
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        m_valid  = 1'b0;
        m_phase  = PH_IDLE;
        m_layer  = 0;
        reset = 1'b1;
        start = 1'b1;
        done  = 1'b1;

        // Reset held for two edges with start and done high.
        tick(2);
        chk("reset_ram", int'(RAM_Controll_Start), 0);
        chk("reset_sum", int'(sum_trigger), 0);
        chk("reset_layer", int'(layer), 0);
        chk("reset_sel", int'(layer_sel), 0);

        // Free run: start and done held high.
        reset = 1'b0;
        tick(1);
        chk("run_c1_ram", int'(RAM_Controll_Start), 1);
        chk("run_c1_layer", int'(layer), 0);
        tick(1);
        chk("run_c2_sum", int'(sum_trigger), 1);
        chk("run_c2_ram", int'(RAM_Controll_Start), 0);
        tick(2);
        chk("run_c4_layer", int'(layer), 1);
        chk("run_c4_sel", int'(layer_sel), 1);
        tick(4);
        chk("run_c8_layer", int'(layer), 2);
        tick(4);
        chk("run_c12_layer", int'(layer), 0);
        chk("run_c12_sel", int'(layer_sel), 0);
        chk("run_c12_ram", int'(RAM_Controll_Start), 0);
        start = 1'b0;
        tick(2);
        chk("run_done_ram", int'(RAM_Controll_Start), 0);
        chk("run_done_layer", int'(layer), 0);

        // Idle gating: done alone does nothing.
        done = 1'b1;
        tick(3);
        chk("idle_ram", int'(RAM_Controll_Start), 0);
        chk("idle_sum", int'(sum_trigger), 0);

        // Handshake stall in LOAD.
        done  = 1'b0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_ram", int'(RAM_Controll_Start), 1);
            tick(1);
        end
        done = 1'b1;
        tick(1);
        chk("stall_exit_ram", int'(RAM_Controll_Start), 0);
        chk("stall_exit_sum", int'(sum_trigger), 1);
        done = 1'b0;
        tick(2);
        chk("sum_hold", int'(sum_trigger), 1);
        done = 1'b1;
        tick(1);
        chk("adv_sum", int'(sum_trigger), 0);
        chk("adv_layer", int'(layer), 0);
        done = 1'b0;
        tick(1);
        chk("after_adv_layer", int'(layer), 1);

        // Inter-layer pause, then resume on layer 1.
        tick(3);
        chk("pause_layer", int'(layer), 1);
        chk("pause_sel", int'(layer_sel), 1);
        chk("pause_ram", int'(RAM_Controll_Start), 0);
        start = 1'b1;
        tick(1);
        chk("resume_ram", int'(RAM_Controll_Start), 1);
        chk("resume_layer", int'(layer), 1);

        // Mid-pass reset while in SUM of layer 1.
        start = 1'b0;
        done  = 1'b1;
        tick(1);
        chk("l1_sum", int'(sum_trigger), 1);
        reset = 1'b1;
        done  = 1'b0;
        tick(1);
        chk("midrst_sum", int'(sum_trigger), 0);
        chk("midrst_layer", int'(layer), 0);
        chk("midrst_ram", int'(RAM_Controll_Start), 0);
        reset = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
